// File: rtl/scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner:
// slot state encoding, segment width and the digit-select decoder.
package scan_pkg;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   localparam int SEG_W = 7;

   // Decode a digit index into a one-hot select (up to 8 digits).
   // Indices outside the bank decode to all-zero.
   function automatic logic [7:0] onehot(input logic [2:0] idx, input int num_dig);
      logic [7:0] r;
      r = 8'h01 << idx;
      if (int'(idx) >= num_dig) r = '0;
      return r;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer for the digit scanner. cnt walks 0..PRESC-1 inside a slot,
// idx walks the digits. Outputs describe the position the next enabled
// edge acts on, so the consumer can register its outputs on that edge.
module scan_timer
   import scan_pkg::*;
#(
   parameter int NUM_DIG   = 4,
   parameter int PRESC     = 1000,
   parameter int BLANK_CYC = 4,
   parameter int CNT_W     = $clog2(PRESC),
   parameter int IDX_W     = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [0:0]       state,
   output logic [IDX_W-1:0] idx,
   output logic [CNT_W-1:0] cnt,
   output logic             slot_end,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC - 1);
   localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   assign cnt        = cnt_q;
   assign idx        = idx_q;
   assign state      = (cnt_q < BLANK_C) ? ST_BLANK : ST_SHOW;
   assign slot_end   = (cnt_q == CNT_LAST);
   assign frame_wrap = slot_end && (idx_q == IDX_LAST);

   // Next counter values: hold at slot 0 while disabled, wrap at slot end.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      if (!en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (slot_end) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

endmodule

// File: rtl/scanare_afisor.sv
// Time-multiplexed 7-segment driver. Latches one pattern per digit on
// load, then scans digits with a blanking gap at the start of every slot
// and pulses frame_done on the first blank cycle of each new frame.
// Optional macro SCAN_DIM_EN adds a 3-bit bright input that PWMs the
// digit select during the show window with duty (bright+1)/8.
module scanare_afisor
   import scan_pkg::*;
#(
   parameter int NUM_DIG   = 4,
   parameter int PRESC     = 1000,
   parameter int BLANK_CYC = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     load,
   input  logic [SEG_W*NUM_DIG-1:0] seg_in,
`ifdef SCAN_DIM_EN
   input  logic [2:0]               bright,
`endif
   output logic [SEG_W-1:0]         seg,
   output logic [NUM_DIG-1:0]       an,
   output logic                     frame_done
);

   localparam int CNT_W = $clog2(PRESC);
   localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
   localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYC);

   logic [0:0]       state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             unused_slot_end;  // frame_wrap already carries the slot qualifier
   logic             frame_wrap;

   scan_timer #(
      .NUM_DIG   (NUM_DIG),
      .PRESC     (PRESC),
      .BLANK_CYC (BLANK_CYC),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .state      (state),
      .idx        (idx),
      .cnt        (cnt),
      .slot_end   (unused_slot_end),
      .frame_wrap (frame_wrap)
   );

   logic [NUM_DIG-1:0][SEG_W-1:0] shadow_q, shadow_d;
   logic [SEG_W-1:0]              seg_q, seg_d;
   logic [NUM_DIG-1:0]            an_q, an_d;
   logic                          frame_done_q, frame_done_d;
   logic                          wrap_q, wrap_d;   // frame closed on the previous edge
   logic                          lit;
   logic [7:0]                    sel;

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

   // Dimming gate: position within the show window modulo 8 vs. brightness.
`ifdef SCAN_DIM_EN
   logic [CNT_W-1:0] show_pos;
   assign show_pos = cnt - BLANK_C;
   assign lit      = (3'(show_pos) <= bright);
`else
   assign lit = 1'b1;
`endif

   assign sel = onehot(3'(idx), NUM_DIG);

   // Shadow capture is independent of scan enable.
   always_comb begin
      shadow_d = load ? seg_in : shadow_q;
   end

   // Output next-state: seg is taken from the pre-load shadow on the
   // blank->show edge and held; blank and disabled cycles drive zeros.
   always_comb begin
      seg_d        = '0;
      an_d         = '0;
      wrap_d       = 1'b0;
      frame_done_d = 1'b0;
      if (en) begin
         wrap_d       = frame_wrap;
         frame_done_d = wrap_q;
         if (state == ST_SHOW) begin
            seg_d = (cnt == BLANK_C) ? shadow_q[idx] : seg_q;
            an_d  = lit ? sel[NUM_DIG-1:0] : '0;
         end
      end
   end

   // Output and shadow registers; reset wins over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q     <= '0;
         seg_q        <= '0;
         an_q         <= '0;
         wrap_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         wrap_q       <= wrap_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_scanare_afisor.sv
// Bench for scanare_afisor: directed test-plan sequence with literal
// expectations, then randomized en/load/rst traffic, all compared every
// cycle against an edge-count based reference model.
module tb_scanare_afisor;

   localparam int ND = 4;
   localparam int PR = 8;
   localparam int BC = 2;

   logic          clk = 1'b0;
   logic          rst, en, load;
   logic [7*ND-1:0] seg_in;
   logic [6:0]    seg;
   logic [ND-1:0] an;
   logic          frame_done;
`ifdef SCAN_DIM_EN
   logic [2:0]    bright;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scanare_afisor #(.NUM_DIG(ND), .PRESC(PR), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .seg_in     (seg_in),
`ifdef SCAN_DIM_EN
      .bright     (bright),
`endif
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   // Reference model: n counts enabled edges since restart; slot, digit
   // and offset follow from plain division.
   logic [6:0]    m_shadow [ND];
   logic [6:0]    m_held, m_seg;
   logic [ND-1:0] m_an;
   logic          m_fd;
   bit            m_valid = 0;
   int            m_n, off, dig;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ND; i++) m_shadow[i] = '0;
         m_n = 0; m_held = '0; m_seg = '0; m_an = '0; m_fd = 1'b0;
         m_valid = 1;
      end else begin
         m_seg = '0; m_an = '0; m_fd = 1'b0;
         if (!en) begin
            m_n = 0;
         end else begin
            off  = m_n % PR;
            dig  = (m_n / PR) % ND;
            m_fd = (m_n > 0) && (m_n % (PR * ND) == 0);
            if (off >= BC) begin
               if (off == BC) m_held = m_shadow[dig];
               m_seg = m_held;
`ifdef SCAN_DIM_EN
               if (((off - BC) % 8) <= int'(bright)) m_an = ND'(1 << dig);
`else
               m_an = ND'(1 << dig);
`endif
            end
            m_n++;
         end
         if (load) for (int i = 0; i < ND; i++) m_shadow[i] = seg_in[7*i +: 7];
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         checks += 3;
         if (an !== m_an) begin
            failures++;
            $display("FAIL model_an t=%0t got=%b exp=%b", $time, an, m_an);
         end
         if (seg !== m_seg) begin
            failures++;
            $display("FAIL model_seg t=%0t got=%h exp=%h", $time, seg, m_seg);
         end
         if (frame_done !== m_fd) begin
            failures++;
            $display("FAIL model_frame_done t=%0t got=%b exp=%b", $time, frame_done, m_fd);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; seg_in = '0;
`ifdef SCAN_DIM_EN
      bright = 3'd7;
`endif
      cyc(); cyc();
      chk("reset_an", 32'(an), 32'h0);
      chk("reset_seg", 32'(seg), 32'h0);
      chk("reset_fd", 32'(frame_done), 32'h0);

      // Preload digits while disabled.
      rst = 1'b0; load = 1'b1;
      seg_in = {7'h4F, 7'h5B, 7'h06, 7'h3F};
      cyc();
      load = 1'b0; en = 1'b1;

      for (int k = 1; k <= 64; k++) begin
         load = 1'b0;
         if (k == 5)  begin load = 1'b1; seg_in = {7'h4F, 7'h5B, 7'h06, 7'h7F}; end
         if (k == 11) begin load = 1'b1; seg_in = {7'h4F, 7'h5B, 7'h66, 7'h7F}; end
         cyc();
         case (k)
            2:  chk("e2_an", 32'(an), 32'h0);
            3:  begin chk("e3_an", 32'(an), 32'h1); chk("e3_seg", 32'(seg), 32'h3F); end
            8:  chk("e8_seg_held", 32'(seg), 32'h3F);
            10: chk("e10_an", 32'(an), 32'h0);
            11: begin chk("e11_an", 32'(an), 32'h2); chk("e11_seg_old", 32'(seg), 32'h06); end
            32: begin chk("e32_an", 32'(an), 32'h8); chk("e32_seg", 32'(seg), 32'h4F);
                      chk("e32_fd", 32'(frame_done), 32'h0); end
            33: begin chk("e33_fd", 32'(frame_done), 32'h1); chk("e33_an", 32'(an), 32'h0); end
            34: chk("e34_fd", 32'(frame_done), 32'h0);
            35: chk("e35_seg_new", 32'(seg), 32'h7F);
            43: begin chk("e43_an", 32'(an), 32'h2); chk("e43_seg_new", 32'(seg), 32'h66); end
            default: ;
         endcase
      end

      // Disable right after a frame wrap: frame_done must stay low.
      load = 1'b0; en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("dis_an", 32'(an), 32'h0);
         chk("dis_seg", 32'(seg), 32'h0);
         chk("dis_fd", 32'(frame_done), 32'h0);
      end
      en = 1'b1;
      cyc(); chk("reen_e1_an", 32'(an), 32'h0);
      cyc(); chk("reen_e2_an", 32'(an), 32'h0);
      cyc(); chk("reen_e3_an", 32'(an), 32'h1); chk("reen_e3_seg", 32'(seg), 32'h7F);

      // Reset together with load: shadow is cleared, load ignored.
      rst = 1'b1; load = 1'b1; seg_in = 28'($urandom) | 28'h1;
      cyc();
      chk("rst_an", 32'(an), 32'h0);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_fd", 32'(frame_done), 32'h0);
      rst = 1'b0; load = 1'b0; en = 1'b1;
      cyc(); cyc(); cyc();
      chk("post_rst_an", 32'(an), 32'h1);
      chk("post_rst_seg", 32'(seg), 32'h0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst  = ($urandom_range(0, 499) == 0);
         en   = ($urandom_range(0, 79) != 0);
         load = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < ND; i++) seg_in[7*i +: 7] = 7'($urandom);
`ifdef SCAN_DIM_EN
         if ($urandom_range(0, 15) == 0) bright = 3'($urandom);
`endif
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
